// File: rtl/wls_pkg.sv
// Shared types and constants for the weight load sequencer.
package wls_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        STREAM    = 3'd2,
        GAP       = 3'd3,
        COMPUTE   = 3'd4,
        WAIT_DONE = 3'd5,
        DONE      = 3'd6,
        ERROR     = 3'd7
    } wls_state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd1;
    localparam logic [1:0] ERR_NO_LAST    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

endpackage

// File: rtl/wls_beat_framer.sv
// Beat counter and tlast checker for one target weight line.
// Counts accepted beats and flags a line that ends early or fails to end
// on its final beat. All flags are qualified by the current beat.
module wls_beat_framer
    import wls_pkg::*;
#(
    parameter int unsigned BEATS_PER_LINE = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic beat,
    input  logic last,
    output logic line_done,
    output logic err_early,
    output logic err_missing
);

    localparam int unsigned CW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam logic [CW-1:0] FINAL_BEAT = CW'(BEATS_PER_LINE - 1);

    logic [CW-1:0] count;
    logic          at_final;

    assign at_final = (count == FINAL_BEAT);

    // Classify the current beat against its position in the line.
    always_comb begin
        line_done   = beat &&  last &&  at_final;
        err_early   = beat &&  last && !at_final;
        err_missing = beat && !last &&  at_final;
    end

    // Beat position within the line; wraps on any line-terminating beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (beat) begin
            if (last || at_final) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// Autonomous run controller: loads one weight line per target core from a
// single AXI-Stream, then starts compute and waits for completion.
// Optional macro WLOAD_CHECKSUM_EN adds o_checksum, the XOR of all counted
// beats of the current run.
module weight_load_sequencer
    import wls_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 64,
    parameter int unsigned NUM_TARGETS     = 5,
    parameter int unsigned BEATS_PER_LINE  = 18,
    parameter int unsigned TARGET_W        = 4,
    parameter int unsigned BASE_W          = 9,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_run,
    input  logic                       i_clear,
    input  logic [BASE_W-1:0]          i_l1_weight_base,
    input  logic [BASE_W-1:0]          i_l2_weight_base,
    input  logic                       s_axis_w_tvalid,
    output logic                       s_axis_w_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_w_tdata,
    input  logic                       s_axis_w_tlast,
    output logic                       m_axis_w_tvalid,
    input  logic                       m_axis_w_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_w_tdata,
    output logic                       m_axis_w_tlast,
`ifdef WLOAD_CHECKSUM_EN
    output logic [AXIS_DATA_WIDTH-1:0] o_checksum,
`endif
    output logic                       o_load_weights,
    output logic [TARGET_W-1:0]        o_target_layer,
    output logic                       o_start_compute,
    output logic [BASE_W-1:0]          o_l1_weight_base,
    output logic [BASE_W-1:0]          o_l2_weight_base,
    input  logic                       i_compute_done,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [1:0]                 o_err_code
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]       WAIT_LIMIT  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TARGET_W-1:0] LAST_TARGET = TARGET_W'(NUM_TARGETS - 1);

    wls_state_t    state;
    logic [TW-1:0] wait_count;
    logic          in_stream;
    logic          beat;
    logic          line_done;
    logic          err_early;
    logic          err_missing;

    // Combinational passthrough, gated so nothing moves outside STREAM.
    always_comb begin
        in_stream       = (state == STREAM);
        m_axis_w_tvalid = in_stream && s_axis_w_tvalid;
        s_axis_w_tready = in_stream && m_axis_w_tready;
        m_axis_w_tdata  = in_stream ? s_axis_w_tdata : '0;
        m_axis_w_tlast  = in_stream && s_axis_w_tlast;
        beat            = m_axis_w_tvalid && m_axis_w_tready;
    end

    wls_beat_framer #(
        .BEATS_PER_LINE(BEATS_PER_LINE)
    ) u_framer (
        .clk        (clk),
        .rst        (rst),
        .clear      (!in_stream),
        .beat       (beat),
        .last       (s_axis_w_tlast),
        .line_done  (line_done),
        .err_early  (err_early),
        .err_missing(err_missing)
    );

    // Run sequencing FSM; every status output is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wait_count       <= '0;
            o_load_weights   <= 1'b0;
            o_target_layer   <= '0;
            o_start_compute  <= 1'b0;
            o_l1_weight_base <= '0;
            o_l2_weight_base <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
            o_err_code       <= ERR_NONE;
        end else begin
            o_load_weights <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_run) begin
                        state            <= ARM;
                        o_target_layer   <= '0;
                        o_l1_weight_base <= i_l1_weight_base;
                        o_l2_weight_base <= i_l2_weight_base;
                        o_load_weights   <= 1'b1;
                        o_busy           <= 1'b1;
                    end
                end
                ARM: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (err_early) begin
                        state      <= ERROR;
                        o_error    <= 1'b1;
                        o_busy     <= 1'b0;
                        o_err_code <= ERR_EARLY_LAST;
                    end else if (err_missing) begin
                        state      <= ERROR;
                        o_error    <= 1'b1;
                        o_busy     <= 1'b0;
                        o_err_code <= ERR_NO_LAST;
                    end else if (line_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (o_target_layer < LAST_TARGET) begin
                        state          <= ARM;
                        o_target_layer <= o_target_layer + TARGET_W'(1);
                        o_load_weights <= 1'b1;
                    end else begin
                        state           <= COMPUTE;
                        o_start_compute <= 1'b1;
                        wait_count      <= '0;
                    end
                end
                COMPUTE: begin
                    state      <= WAIT_DONE;
                    wait_count <= '0;
                end
                WAIT_DONE: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (i_compute_done) begin
                        state           <= DONE;
                        o_start_compute <= 1'b0;
                        o_done          <= 1'b1;
                    end else if (wait_count == WAIT_LIMIT) begin
                        state           <= ERROR;
                        o_start_compute <= 1'b0;
                        o_error         <= 1'b1;
                        o_busy          <= 1'b0;
                        o_err_code      <= ERR_TIMEOUT;
                    end else begin
                        wait_count <= wait_count + TW'(1);
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    o_busy         <= 1'b0;
                    o_target_layer <= '0;
                end
                ERROR: begin
                    if (i_clear) begin
                        state          <= IDLE;
                        o_error        <= 1'b0;
                        o_err_code     <= ERR_NONE;
                        o_target_layer <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    // Running XOR of counted beats, restarted when a run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_checksum <= '0;
        end else if (state == IDLE && i_run) begin
            o_checksum <= '0;
        end else if (beat) begin
            o_checksum <= o_checksum ^ s_axis_w_tdata;
        end
    end
`endif

endmodule

// File: doc/weight_load_sequencer.md
Name: weight_load_sequencer

Overview:
- Autonomous run controller in front of fpga_top_level.
- On one run command it:
  - loads one weight line into every target core (L1 cores 0..3, L2 core 4) from a single upstream AXI-Stream;
  - drives the load pulse and target select for each core;
  - raises start-compute and waits for compute-done.
- Replaces per-target host sequencing.
- Flags stream framing errors and compute timeouts.

Parameters:
- AXIS_DATA_WIDTH, 64, weight stream width
- NUM_TARGETS, 5, cores loaded per run, IDs 0..NUM_TARGETS-1
- BEATS_PER_LINE, 18, beats per target weight line
- TARGET_W, 4, target ID width
- BASE_W, 9, weight base address width
- TIMEOUT_CYCLES, 65535, max cycles waiting for compute done

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_run  in  1  start pulse; ignored unless IDLE
- i_clear  in  1  leave ERROR state
- i_l1_weight_base  in  BASE_W  sampled on accepted i_run
- i_l2_weight_base  in  BASE_W  sampled on accepted i_run
- s_axis_w_tvalid  in  1  upstream weight valid
- s_axis_w_tready  out  1  upstream ready
- s_axis_w_tdata  in  AXIS_DATA_WIDTH  upstream data
- s_axis_w_tlast  in  1  end of one target line
- m_axis_w_tvalid  out  1  to core weight port
- m_axis_w_tready  in  1  from core weight port
- m_axis_w_tdata  out  AXIS_DATA_WIDTH  passthrough data
- m_axis_w_tlast  out  1  passthrough last
- o_load_weights  out  1  one-cycle arm pulse per target
- o_target_layer  out  TARGET_W  current target ID
- o_start_compute  out  1  level, held until done
- o_l1_weight_base  out  BASE_W  latched base
- o_l2_weight_base  out  BASE_W  latched base
- i_compute_done  in  1  from datapath
- o_busy  out  1  high outside IDLE and ERROR
- o_done  out  1  one-cycle pulse on run completion
- o_error  out  1  high in ERROR
- o_err_code  out  2  1=early tlast, 2=missing tlast, 3=timeout

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Asserting rst at any point, including mid-stream, returns to IDLE within the same edge and drops ready, valid and start.
- States:
  - IDLE -> ARM on i_run. Latches both bases and sets target=0.
  - ARM: o_load_weights=1 for exactly one cycle, o_target_layer=target. Next state STREAM.
  - STREAM:
    - Passthrough is combinational: m_tvalid=s_tvalid, s_tready=m_tready, data and last forwarded.
    - A beat counts only when m_tvalid && m_tready.
    - Beat counter runs 0..BEATS_PER_LINE-1.
  - Counted beat with tlast and count<BEATS_PER_LINE-1 -> ERROR, code 1.
  - Counted beat with count==BEATS_PER_LINE-1 and no tlast -> ERROR, code 2.
  - Final beat with tlast -> GAP.
  - GAP: one idle cycle, ready low.
    - If target<NUM_TARGETS-1: target+1 -> ARM.
    - Otherwise -> COMPUTE.
  - COMPUTE: o_start_compute=1, timeout counter cleared -> WAIT_DONE.
  - WAIT_DONE: o_start_compute stays 1.
    - i_compute_done high -> DONE.
    - Counter reaching TIMEOUT_CYCLES -> ERROR, code 3.
    - If done and timeout occur in the same cycle, done wins.
  - DONE: o_done=1 for one cycle, o_start_compute=0 -> IDLE.
  - ERROR: ready and valid forced 0, start 0, o_error=1, code held.
    - i_clear -> IDLE with code cleared.
    - i_run in ERROR is ignored.
- Outside STREAM: s_axis_w_tready=0 and m_axis_w_tvalid=0.
- o_target_layer holds its value from ARM through GAP. It is 0 in IDLE.
- i_run while busy: ignored, with no effect on latched bases.
- Minimum run latency: NUM_TARGETS*(BEATS_PER_LINE+2)+2 cycles plus compute time.

Optional Feature:
- WLOAD_CHECKSUM_EN
- With macro:
  - Adds output o_checksum [AXIS_DATA_WIDTH-1:0], the XOR of all counted beats of the current run.
  - Cleared when ARM is entered for target 0.
  - Valid from DONE until the next run.
- Without macro: port and logic absent. The remaining behaviour is identical.

Decomposition:
- Shared package wls_pkg holds:
  - state enum: IDLE, ARM, STREAM, GAP, COMPUTE, WAIT_DONE, DONE, ERROR;
  - error code constants ERR_NONE=0, ERR_EARLY_LAST=1, ERR_NO_LAST=2, ERR_TIMEOUT=3.
- One natural sub-module, wls_beat_framer:
  - beat counter plus tlast checker;
  - outputs line_done, err_early, err_missing.
- FSM, passthrough and timeout counter stay in the top.

Test Plan:
- Normal run, all targets:
  - Stimulus: i_run; 5 lines of 18 beats (tlast on beat 17) with m_tready=1; i_compute_done 40 cycles after start.
  - Required: 5 o_load_weights pulses with targets 0,1,2,3,4; o_start_compute high until done; o_done pulse; o_error=0.
- Backpressure:
  - Stimulus: m_tready toggled every other cycle and s_tvalid randomly gapped.
  - Required: exactly 90 counted beats, no beat duplicated or dropped, s_tready mirrors m_tready only in STREAM.
- Early tlast:
  - Stimulus: tlast on beat 10 of target 2.
  - Required: o_error=1, o_err_code=1, ready 0, target holds 2; i_clear returns to IDLE.
- Missing tlast:
  - Stimulus: beat 17 of target 0 sent without tlast.
  - Required: o_err_code=2.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100 and done never asserted.
  - Required: ERROR with code 3 after 100 WAIT_DONE cycles; o_start_compute=0.
- Reset mid-stream and run while busy:
  - Stimulus: rst asserted at beat 5 of target 3.
  - Required: all outputs 0 immediately; a fresh i_run restarts at target 0.
  - Stimulus: i_run during STREAM.
  - Required: no effect.
